mac_accum_8x8: RTL and testbench

- Sequential accumulation stage directly downstream of the 8x8 combinational multiplier.
- Consumes the 16-bit PROD stream over a valid/ready handshake and sums a programmed number of products into a wide accumulator.
- Presents the final sum on an output valid/ready handshake, together with a sticky overflow flag.
- Turns the single-shot multiplier into a dot-product / multiply-accumulate datapath.

---
 rtl/mac_accum_8x8_if.sv | 28 ++
 rtl/mac_accum_8x8.sv | 88 ++++++++
 tb/tb_mac_accum_8x8.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_accum_8x8_if.sv
// Handshake bundle between the 8x8 multiplier stream, the accumulator and its consumer.
// The master side drives the command and product stream; the slave side is the accumulator.
interface mac_accum_8x8_if #(
   parameter int PROD_WIDTH = 16,
   parameter int ACC_WIDTH  = 24,
   parameter int LEN_WIDTH  = 8
);
   logic                  start;
   logic [LEN_WIDTH-1:0]  len;
   logic                  in_valid;
   logic                  in_ready;
   logic [PROD_WIDTH-1:0] prod_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [ACC_WIDTH-1:0]  acc_out;
   logic                  overflow;
   logic                  busy;

   modport master (
      output start, len, in_valid, prod_in, out_ready,
      input  in_ready, out_valid, acc_out, overflow, busy
   );

   modport slave (
      input  start, len, in_valid, prod_in, out_ready,
      output in_ready, out_valid, acc_out, overflow, busy
   );
endinterface

// File: rtl/mac_accum_8x8.sv
// Multiply-accumulate stage: sums a programmed number of unsigned products into a
// wide wrapping accumulator and returns the result with a sticky carry-out flag.
module mac_accum_8x8 #(
   parameter int PROD_WIDTH = 16,
   parameter int ACC_WIDTH  = 24,
   parameter int LEN_WIDTH  = 8
) (
   input logic             clk,
   input logic             rst_n,
   mac_accum_8x8_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic                   ovf_q, ovf_d;
   logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
   logic [ACC_WIDTH:0]     sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   // One extra adder bit captures the carry out of the accumulator width.
   assign sum = {1'b0, acc_q} + {{(ACC_WIDTH - PROD_WIDTH + 1){1'b0}}, bus.prod_in};

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               acc_d = '0;
               ovf_d = 1'b0;
               if (bus.len != '0) begin
                  cnt_d   = bus.len;
                  state_d = ACC;
               end else begin
                  state_d = DONE;
               end
            end
         end
         ACC: begin
            // in_ready is high throughout ACC, so in_valid alone marks a transfer.
            if (bus.in_valid) begin
               acc_d = sum[ACC_WIDTH-1:0];
               ovf_d = ovf_q | sum[ACC_WIDTH];
               cnt_d = cnt_q - LEN_WIDTH'(1);
               if (cnt_q == LEN_WIDTH'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == ACC);
      bus.out_valid = (state_q == DONE);
      bus.busy      = (state_q != IDLE);
      bus.acc_out   = acc_q;
      bus.overflow  = ovf_q;
   end

endmodule

// File: tb/tb_mac_accum_8x8.sv
// Bench for mac_accum_8x8: a 24-bit and a 16-bit accumulator share one stimulus stream
// and are checked by a queue-based scoreboard against a plain-arithmetic sum model.
module tb_mac_accum_8x8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  len = '0;
   logic        in_valid = 1'b0;
   logic [15:0] prod_in = '0;
   logic        out_ready = 1'b0;

   always #5 clk = ~clk;

   mac_accum_8x8_if #(.PROD_WIDTH(16), .ACC_WIDTH(24), .LEN_WIDTH(8)) ifa ();
   mac_accum_8x8_if #(.PROD_WIDTH(16), .ACC_WIDTH(16), .LEN_WIDTH(8)) ifb ();

   assign ifa.start     = start;
   assign ifa.len       = len;
   assign ifa.in_valid  = in_valid;
   assign ifa.prod_in   = prod_in;
   assign ifa.out_ready = out_ready;
   assign ifb.start     = start;
   assign ifb.len       = len;
   assign ifb.in_valid  = in_valid;
   assign ifb.prod_in   = prod_in;
   assign ifb.out_ready = out_ready;

   mac_accum_8x8 #(.PROD_WIDTH(16), .ACC_WIDTH(24), .LEN_WIDTH(8)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa.slave)
   );

   mac_accum_8x8 #(.PROD_WIDTH(16), .ACC_WIDTH(16), .LEN_WIDTH(8)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb.slave)
   );

   typedef struct {
      longint unsigned acc;
      bit              ovf;
   } exp_t;

   exp_t            qa[$];
   exp_t            qb[$];
   int unsigned     prods[$];
   longint unsigned last_a = 0;
   longint unsigned last_b = 0;
   int              checks = 0;
   int              failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every cycle a DUT presents a result it must match the queue head.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (ifa.out_valid === 1'b1) begin
            if (qa.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL a_unexpected_result: out_valid=1 acc_out=0x%0h, no result expected", ifa.acc_out);
            end else begin
               chk("a_acc_out", 64'(ifa.acc_out), qa[0].acc);
               chk("a_overflow", 64'(ifa.overflow), 64'(qa[0].ovf));
               chk("a_busy_in_done", 64'(ifa.busy), 64'd1);
               if (out_ready) void'(qa.pop_front());
            end
         end
         if (ifb.out_valid === 1'b1) begin
            if (qb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL b_unexpected_result: out_valid=1 acc_out=0x%0h, no result expected", ifb.acc_out);
            end else begin
               chk("b_acc_out", 64'(ifb.acc_out), qb[0].acc);
               chk("b_overflow", 64'(ifb.overflow), 64'(qb[0].ovf));
               chk("b_busy_in_done", 64'(ifb.busy), 64'd1);
               if (out_ready) void'(qb.pop_front());
            end
         end
      end
   end

   task automatic send_beat(input int unsigned p);
      int guard;
      guard = 0;
      in_valid = 1'b1;
      prod_in  = 16'(p);
      while (ifa.in_ready !== 1'b1 && guard < 50) begin
         step();
         guard++;
      end
      if (guard >= 50) begin
         checks++;
         failures++;
         $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", ifa.in_ready, guard);
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_a_acc_out"}, 64'(ifa.acc_out), 64'd0);
      chk({tag, "_a_overflow"}, 64'(ifa.overflow), 64'd0);
      chk({tag, "_a_busy"}, 64'(ifa.busy), 64'd0);
      chk({tag, "_a_in_ready"}, 64'(ifa.in_ready), 64'd0);
      chk({tag, "_a_out_valid"}, 64'(ifa.out_valid), 64'd0);
      chk({tag, "_b_acc_out"}, 64'(ifb.acc_out), 64'd0);
      chk({tag, "_b_out_valid"}, 64'(ifb.out_valid), 64'd0);
   endtask

   // One accumulation over the products in prods. bub<0 picks random bubbles;
   // hold cycles of out_ready=0 precede the handshake; poke pulses start during ACC.
   task automatic run(input int bub, input int hold, input bit poke);
      longint unsigned s;
      int              nb;
      s = 0;
      foreach (prods[i]) s += prods[i];
      chk("idle_before_start", 64'(ifa.busy), 64'd0);
      qa.push_back('{s % 64'd16777216, s >= 64'd16777216});
      qb.push_back('{s % 64'd65536, s >= 64'd65536});
      last_a = s % 64'd16777216;
      last_b = s % 64'd65536;
      out_ready = (hold == 0);
      len   = 8'(prods.size());
      start = 1'b1;
      step();
      start = 1'b0;
      len   = 8'($urandom);
      if (prods.size() == 0) chk("zero_len_in_ready", 64'(ifa.in_ready), 64'd0);
      foreach (prods[i]) begin
         send_beat(prods[i]);
         if (i < prods.size() - 1) begin
            nb = (bub >= 0) ? bub : int'($urandom_range(0, 3));
            repeat (nb) begin
               if (poke) begin
                  start = 1'b1;
                  len   = 8'($urandom_range(1, 255));
               end
               prod_in = 16'($urandom);
               step();
               start = 1'b0;
               chk("busy_in_acc", 64'(ifa.busy), 64'd1);
            end
         end
      end
      chk("a_out_valid_latency", 64'(ifa.out_valid), 64'd1);
      chk("b_out_valid_latency", 64'(ifb.out_valid), 64'd1);
      chk("in_ready_in_done", 64'(ifa.in_ready), 64'd0);
      repeat (hold) begin
         in_valid = 1'($urandom);
         prod_in  = 16'($urandom);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("idle_after_handshake", 64'(ifa.busy), 64'd0);
      chk("out_valid_after_handshake", 64'(ifa.out_valid), 64'd0);
      chk("a_acc_hold_in_idle", 64'(ifa.acc_out), last_a);
      chk("b_acc_hold_in_idle", 64'(ifb.acc_out), last_b);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_cleared("reset");
      rst_n = 1'b1;
      step();

      prods = '{65025, 65025, 65025};
      run(0, 0, 1'b0);

      prods = '{32'h0001, 32'h0100};
      run(5, 4, 1'b0);

      prods = '{65025, 65025};
      run(0, 0, 1'b0);
      prods = '{5};
      run(0, 0, 1'b0);

      prods.delete();
      run(0, 2, 1'b0);

      prods = '{300, 7000, 12};
      run(2, 1, 1'b1);

      prods = '{32'h00FF};
      run(0, 0, 1'b0);
      prods = '{32'h0002};
      run(0, 0, 1'b0);

      // Abort mid-run: two beats in, then reset between clock edges.
      out_ready = 1'b0;
      len   = 8'd4;
      start = 1'b1;
      step();
      start = 1'b0;
      send_beat(16);
      send_beat(16);
      #3 rst_n = 1'b0;
      #2 check_cleared("midrun_reset");
      @(negedge clk);
      #2 rst_n = 1'b1;
      in_valid = 1'b1;
      prod_in  = 16'h0010;
      repeat (6) step();
      in_valid = 1'b0;
      chk("after_reset_busy", 64'(ifa.busy), 64'd0);
      chk("after_reset_out_valid", 64'(ifa.out_valid), 64'd0);

      for (int r = 0; r < 40; r++) begin
         int unsigned n;
         n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
         prods.delete();
         for (int k = 0; k < int'(n); k++) begin
            prods.push_back(($urandom_range(0, 3) == 0) ? 65025 : $urandom_range(0, 65535));
         end
         run(-1, int'($urandom_range(0, 3)), 1'($urandom));
      end

      chk("a_queue_drained", 64'(qa.size()), 64'd0);
      chk("b_queue_drained", 64'(qb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
